// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Two-requester round-robin arbiter in front of a single-port data memory
//   with a combinational read path. A grant is a one-cycle pulse in IDLE.
//   The following ACCESS cycle drives the memory from latched request
//   fields. A read returns registered data with an rvalid pulse one cycle
//   later, so the path from gnt to rvalid is two cycles.
//
// Ports
//   CLK, RST                    clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata    requester N request; held stable until gnt
//   reqN_gnt                    one-cycle request-accepted pulse
//   reqN_rvalid/rdata           one-cycle read-return pulse, registered data
//   mem_addr/mem_din/mem_we     to data memory; zero outside ACCESS
//   mem_dout                    from data memory (combinational read)
//   busy                        high while in ACCESS
module data_mem_arbiter (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req0_valid,
    input  logic       req0_we,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic       req0_gnt,
    output logic       req0_rvalid,
    output logic [7:0] req0_rdata,
    input  logic       req1_valid,
    input  logic       req1_we,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       req1_gnt,
    output logic       req1_rvalid,
    output logic [7:0] req1_rdata,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       mem_we,
    input  logic [7:0] mem_dout,
    output logic       busy
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state, state_nxt;
    logic       last_served;   // 1: requester 1 was granted most recently
    logic       lat_we;
    logic       lat_owner;
    logic [7:0] lat_addr;
    logic [7:0] lat_wdata;

    // Next state and grants. On a tie, requester 0 wins only when requester 1
    // was served last; RST suppresses any grant in the same cycle.
    always_comb begin
        state_nxt = state;
        req0_gnt  = 1'b0;
        req1_gnt  = 1'b0;
        case (state)
            IDLE: begin
                if (!RST) begin
                    if (req0_valid && (!req1_valid || last_served))
                        req0_gnt = 1'b1;
                    else if (req1_valid)
                        req1_gnt = 1'b1;
                    if (req0_gnt || req1_gnt)
                        state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory drive. mem_we is gated by RST combinationally so a reset landing
    // in ACCESS aborts the write before the closing edge can commit it.
    always_comb begin
        busy     = (state == ACCESS);
        mem_addr = busy ? lat_addr  : '0;
        mem_din  = busy ? lat_wdata : '0;
        mem_we   = busy && lat_we && !RST;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            last_served <= 1'b1;
            lat_we      <= 1'b0;
            lat_owner   <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            state       <= state_nxt;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            if (req0_gnt || req1_gnt) begin
                lat_we      <= req1_gnt ? req1_we    : req0_we;
                lat_addr    <= req1_gnt ? req1_addr  : req0_addr;
                lat_wdata   <= req1_gnt ? req1_wdata : req0_wdata;
                lat_owner   <= req1_gnt;
                last_served <= req1_gnt;
            end
            if (state == ACCESS && !lat_we) begin
                if (lat_owner) begin
                    req1_rdata  <= mem_dout;
                    req1_rvalid <= 1'b1;
                end else begin
                    req0_rdata  <= mem_dout;
                    req0_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 CLK  input  1  system clock; all state changes on posedge CLK.
REQ-002 RST  input  1  reset; synchronous and active-high.
REQ-003 req0_valid  input  1  requester 0 (core load/store port) access request.
REQ-004 req0_we  input  1  requester 0 write (1) / read (0).
REQ-005 req0_addr  input  8  requester 0 memory address.
REQ-006 req0_wdata  input  8  requester 0 write data.
REQ-007 req0_gnt  output  1  one-cycle pulse: requester 0 request accepted.
REQ-008 req0_rvalid  output  1  one-cycle pulse: req0_rdata holds read result.
REQ-009 req0_rdata  output  8  requester 0 read data, registered.
REQ-010 req1_valid, req1_we, req1_addr, req1_wdata, req1_gnt, req1_rvalid, req1_rdata  SHALL mirror REQ-003..REQ-009 for requester 1 (loader/debug port).
REQ-011 mem_addr  output  8  to data memory addr_in.
REQ-012 mem_din  output  8  to data memory data_in.
REQ-013 mem_we  output  1  to data memory writemem_ctrl.
REQ-014 mem_dout  input  8  from data memory data_out (combinational read).
REQ-015 busy  output  1  high while in ACCESS state.

Function
REQ-016 FSM SHALL have two states: IDLE, ACCESS; reset state IDLE.
REQ-017 IDLE, no valid: stay IDLE; no gnt.
REQ-018 IDLE, exactly one valid: SHALL pulse that gnt this cycle, latch its we/addr/wdata and requester id, go to ACCESS next cycle.
REQ-019 IDLE, both valid: SHALL grant the requester not served last (round-robin); last-served pointer resets to 1 so requester 0 wins the first tie.
REQ-020 Last-served pointer SHALL update only on a grant.
REQ-021 ACCESS: mem_addr/mem_din/mem_we SHALL be driven from latched values; write commits at the closing posedge; FSM returns to IDLE next cycle unconditionally.
REQ-022 Outside ACCESS, mem_we SHALL be 0, mem_addr 0, mem_din 0.
REQ-023 ACCESS read: mem_dout SHALL be registered into the owning reqN_rdata at the closing posedge, and reqN_rvalid SHALL pulse for exactly the following cycle.
REQ-024 ACCESS write: no rvalid; rdata registers SHALL hold previous values.
REQ-025 Latency: gnt in cycle N, memory access in N+1, rvalid/rdata in N+2; max throughput one access per 2 cycles.
REQ-026 Arbitration in IDLE SHALL proceed in the same cycle as a pending rvalid (overlap permitted).
REQ-027 Requests SHALL be ignored (no gnt) while in ACCESS; requesters hold valid and fields stable until gnt.
REQ-028 gnt SHALL never assert for both requesters in one cycle; at most one access in flight.
REQ-029 Read-after-write to the same address from either requester SHALL return the written value (second access begins after write commit).

Reset
REQ-030 With RST high at a posedge: state IDLE, pointer 1, all gnt/rvalid 0, rdata 0, mem_we 0, mem_addr 0, mem_din 0, busy 0.
REQ-031 RST asserted during ACCESS SHALL abort the access: mem_we forced 0 combinationally while RST high, no write commit, no rvalid afterwards.
REQ-032 RST SHALL take priority over all requests in the same cycle.

Verification
REQ-033 req0 write addr 0x2A data 0x21 -> req0_gnt in cycle N, mem_we=1 addr 0x2A din 0x21 in N+1; then req0 read 0x2A -> req0_rvalid with rdata 0x21 two cycles after its gnt.
REQ-034 Both valid from reset, both reads (0x01, 0x02) -> req0 granted first, req1 granted 2 cycles later; rvalids in order req0 then req1, never simultaneous.
REQ-035 Both held valid continuously for 8 cycles -> grants alternate 0,1,0,1 every 2 cycles; busy toggles 1,0.
REQ-036 req1 write 0x05 to 0x10, req0 read 0x10 presented one cycle later -> req0 rdata 0x05.
REQ-037 RST asserted in ACCESS of a write to 0x30 (prior 0x00) -> mem_we 0, memory 0x30 stays 0x00, no rvalid, outputs at reset values.
REQ-038 req0 valid held during ACCESS of req1 -> no gnt during ACCESS; req0_gnt in the next IDLE cycle.
